tetris_game_ctrl: RTL
=====================

// Module: tetris_game_ctrl
// PURPOSE
//  Single-clock, parametrised top-level game sequencer for the Tetris datapath.
//  Issues one-cycle start pulses to the gen/move/land/clear units, waits on their done handshakes,
//  owns the gravity drop timer, pause, line counting and level progression.
//  Sits above the piece generator, move unit, landing checker and row-clear unit.
// PARAMETERS
//  ROWS             20  board height; width of full_rows / clear_mask
//  LINE_W           16  width of lines_total (saturating)
//  LVL_W             4  width of level
//  LINES_PER_LEVEL  10  cleared lines needed per level step (>=1)
//  MAX_LEVEL        15  level saturation value (< 2**LVL_W)
//  DROP_BASE        48  drop interval in clka cycles at level 0
//  DROP_STEP         4  interval reduction per level
//  DROP_MIN          4  minimum interval (>=1)
//  TMR_W             8  drop timer width (must hold DROP_BASE)
// PORTS
//  clka         in   1       system clock, rising edge
//  restart_n    in   1       asynchronous active-low reset
//  start        in   1       begin game (honoured in NEWBOARD only)
//  restart      in   1       synchronous soft restart, any state -> NEWBOARD
//  pause        in   1       1-cycle toggle request (MOVE<->PAUSE)
//  gen_done     in   1       generator finished
//  gen_blocked  in   1       qualifies gen_done: spawn overlaps stack
//  landed       in   1       move unit: piece can no longer fall
//  land_done    in   1       landing checker finished; full_rows valid this cycle
//  full_rows    in   ROWS    1 = row full, sampled with land_done
//  clear_done   in   1       row-clear unit finished
//  state        out  3       current state encoding
//  start_gen    out  1       1-cycle pulse on GEN entry
//  start_move   out  1       1-cycle pulse on MOVE entry from GEN
//  start_land   out  1       1-cycle pulse on LAND entry
//  start_clear  out  1       1-cycle pulse on CLEAR entry
//  drop_tick    out  1       1-cycle gravity pulse to move unit
//  clear_mask   out  ROWS    registered full_rows, stable throughout CLEAR
//  lines_total  out  LINE_W  total lines cleared this game
//  level        out  LVL_W   current level
//  game_over    out  1       high while in GAMEOVER
// BEHAVIOUR
//  States: NEWBOARD=0 GEN=1 MOVE=2 LAND=3 CLEAR=4 GAMEOVER=5 PAUSE=6; 7 illegal -> NEWBOARD.
//  Reset (restart_n=0): state=NEWBOARD; all pulses, drop_tick, clear_mask, lines_total, level,
//   game_over, timer, level-progress counter = 0. Mid-operation reset aborts immediately.
//  All outputs registered; a start_* pulse is high in the first cycle the state reads the new value.
//  Transitions (priority: restart > others):
//   NEWBOARD: start -> GEN; clears lines_total, level, progress.
//   GEN: gen_done&gen_blocked -> GAMEOVER; gen_done&!gen_blocked -> MOVE.
//   MOVE: landed -> LAND; else pause -> PAUSE.  landed beats pause same cycle.
//   PAUSE: pause -> MOVE (no start_move pulse; timer resumes from frozen value).
//   LAND: land_done & |full_rows -> CLEAR, clear_mask<=full_rows; land_done & full_rows==0 -> GEN.
//   CLEAR: clear_done -> GEN; clear_mask<=0 on exit.
//   GAMEOVER: holds until restart.
//  done inputs are ignored outside their owning state; done present on the entry cycle is accepted.
//  Drop timer: loaded with interval on MOVE entry from GEN; decrements each MOVE cycle; at 1 pulses
//   drop_tick and reloads. Frozen in PAUSE. Cleared in all other states.
//   landed and expiry same cycle -> no drop_tick.
//   interval = (level*DROP_STEP >= DROP_BASE-DROP_MIN) ? DROP_MIN : DROP_BASE-level*DROP_STEP,
//   evaluated at load time (level change mid-MOVE takes effect on next reload).
//  On clear_done: n=popcount(clear_mask); lines_total += n, saturating at 2**LINE_W-1;
//   progress += n; if progress >= LINES_PER_LEVEL: progress -= LINES_PER_LEVEL and level+1
//   saturating at MAX_LEVEL. At most one level step per clear; excess carries.
//  restart in any state: next cycle NEWBOARD, pulses/drop_tick/clear_mask/game_over = 0;
//   lines_total/level kept until next start.
// TESTING
//  1 reset, start=1 one cycle -> state 0->1, start_gen=1 one cycle; gen_done=1 -> state=2, start_move=1.
//  2 level 0 in MOVE, no landed -> drop_tick every 48 cycles exactly; level=11 -> 4; level=12 -> 4 (clamp).
//  3 landed; land_done with full_rows=20'h0000C -> CLEAR, clear_mask=0x0000C; clear_done -> lines_total+=2, GEN.
//  4 progress 9, clear 4 rows -> level+1, progress 3; level 15 + another step -> level stays 15.
//  5 MOVE timer=10, pause pulse -> PAUSE 30 cycles no drop_tick; pause again -> tick after 9 more cycles.
//  6 gen_done&gen_blocked -> GAMEOVER, game_over=1; restart -> NEWBOARD; restart_n low in CLEAR -> all outputs 0.

Source files
------------

// File: rtl/tetris_game_ctrl.sv
// Purpose: top-level Tetris game sequencer; pulses gen/move/land/clear units, owns gravity, pause, lines, level.
// Latency: every output is registered; start_* pulses appear in the first cycle the state shows the new value.
// Backpressure: none issued; waits indefinitely on each unit's done handshake, which is ignored outside its state.
//
// Ports:
//   clka, restart_n                - clock (rising edge) and async active-low reset
//   start, restart, pause          - player controls (start in NEWBOARD, soft restart anywhere, pause toggle)
//   gen_done, gen_blocked          - generator handshake; blocked spawn ends the game
//   landed                         - move unit reports piece resting
//   land_done, full_rows           - landing checker handshake with full-row vector
//   clear_done                     - row-clear unit handshake
//   state                          - current state encoding
//   start_gen/move/land/clear      - one-cycle start pulses to the units
//   drop_tick                      - one-cycle gravity pulse
//   clear_mask                     - latched full rows, stable through CLEAR
//   lines_total, level, game_over  - score and status
module tetris_game_ctrl #(
    parameter int ROWS            = 20,
    parameter int LINE_W          = 16,
    parameter int LVL_W           = 4,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15,
    parameter int DROP_BASE       = 48,
    parameter int DROP_STEP       = 4,
    parameter int DROP_MIN        = 4,
    parameter int TMR_W           = 8
) (
    input  logic              clka,
    input  logic              restart_n,
    input  logic              start,
    input  logic              restart,
    input  logic              pause,
    input  logic              gen_done,
    input  logic              gen_blocked,
    input  logic              landed,
    input  logic              land_done,
    input  logic [ROWS-1:0]   full_rows,
    input  logic              clear_done,
    output logic [2:0]        state,
    output logic              start_gen,
    output logic              start_move,
    output logic              start_land,
    output logic              start_clear,
    output logic              drop_tick,
    output logic [ROWS-1:0]   clear_mask,
    output logic [LINE_W-1:0] lines_total,
    output logic [LVL_W-1:0]  level,
    output logic              game_over
);

    typedef enum logic [2:0] {
        ST_NEWBOARD = 3'd0,
        ST_GEN      = 3'd1,
        ST_MOVE     = 3'd2,
        ST_LAND     = 3'd3,
        ST_CLEAR    = 3'd4,
        ST_GAMEOVER = 3'd5,
        ST_PAUSE    = 3'd6
    } state_t;

    localparam int CNT_W    = $clog2(ROWS + 1);
    localparam int SUM_W    = LINE_W + 1;
    // Progress can carry past LINES_PER_LEVEL when a clear removes many rows;
    // one spare bit plus saturation keeps it bounded.
    localparam int PROG_W   = LINE_W + 1;
    localparam int BASE_GAP = DROP_BASE - DROP_MIN;

    state_t             cur_state;
    state_t             nxt_state;
    logic [TMR_W-1:0]   tmr;
    logic [PROG_W-1:0]  progress;

    logic [TMR_W-1:0]   tmr_nxt;
    logic               tick_nxt;
    logic [TMR_W-1:0]   interval;
    logic [31:0]        lvl_prod;
    logic [CNT_W-1:0]   pop_cnt;
    logic [SUM_W-1:0]   lines_sum;
    logic [PROG_W:0]    prog_sum;
    logic [PROG_W-1:0]  prog_sat;
    logic [ROWS-1:0]    mask_nxt;
    logic [LINE_W-1:0]  lines_nxt;
    logic [LVL_W-1:0]   level_nxt;
    logic [PROG_W-1:0]  progress_nxt;
    logic               clr_evt;

    assign state = cur_state;

    // ------------------------------------------------------------------
    // Next-state logic; soft restart overrides every transition.
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_NEWBOARD: if (start) nxt_state = ST_GEN;
            ST_GEN: begin
                if (gen_done) nxt_state = gen_blocked ? ST_GAMEOVER : ST_MOVE;
            end
            ST_MOVE: begin
                if (landed)     nxt_state = ST_LAND;
                else if (pause) nxt_state = ST_PAUSE;
            end
            ST_PAUSE:    if (pause) nxt_state = ST_MOVE;
            ST_LAND: begin
                if (land_done) nxt_state = (|full_rows) ? ST_CLEAR : ST_GEN;
            end
            ST_CLEAR:    if (clear_done) nxt_state = ST_GEN;
            ST_GAMEOVER: nxt_state = ST_GAMEOVER;
            default:     nxt_state = ST_NEWBOARD;
        endcase
        if (restart) nxt_state = ST_NEWBOARD;
    end

    // ------------------------------------------------------------------
    // Gravity interval at the current level, clamped at DROP_MIN.
    // ------------------------------------------------------------------
    always_comb begin
        lvl_prod = 32'(level) * 32'(DROP_STEP);
        if (lvl_prod >= 32'(BASE_GAP)) interval = TMR_W'(DROP_MIN);
        else                           interval = TMR_W'(32'(DROP_BASE) - lvl_prod);
    end

    // ------------------------------------------------------------------
    // Drop timer: counts in MOVE (including the cycle a pause is taken),
    // holds in PAUSE, cleared elsewhere. A landing cycle suppresses the tick
    // because the next state is LAND, which clears the timer.
    // ------------------------------------------------------------------
    always_comb begin
        tmr_nxt  = '0;
        tick_nxt = 1'b0;
        if (cur_state == ST_GEN && nxt_state == ST_MOVE) begin
            tmr_nxt = interval;
        end else if (cur_state == ST_MOVE &&
                     (nxt_state == ST_MOVE || nxt_state == ST_PAUSE)) begin
            if (tmr == TMR_W'(1)) begin
                tick_nxt = 1'b1;
                tmr_nxt  = interval;
            end else begin
                tmr_nxt = tmr - TMR_W'(1);
            end
        end else if (cur_state == ST_PAUSE && nxt_state != ST_NEWBOARD) begin
            tmr_nxt = tmr;
        end
    end

    // ------------------------------------------------------------------
    // Clear mask and scoring.
    // ------------------------------------------------------------------
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < ROWS; i++) begin
            pop_cnt = pop_cnt + CNT_W'(clear_mask[i]);
        end
    end

    assign clr_evt = (cur_state == ST_CLEAR) && clear_done && !restart;

    always_comb begin
        mask_nxt     = clear_mask;
        lines_nxt    = lines_total;
        level_nxt    = level;
        progress_nxt = progress;

        lines_sum = SUM_W'(lines_total) + SUM_W'(pop_cnt);
        prog_sum  = (PROG_W + 1)'(progress) + (PROG_W + 1)'(pop_cnt);
        prog_sat  = prog_sum[PROG_W] ? {PROG_W{1'b1}} : prog_sum[PROG_W-1:0];

        if (cur_state == ST_LAND && nxt_state == ST_CLEAR) begin
            mask_nxt = full_rows;
        end else if (cur_state == ST_CLEAR && nxt_state != ST_CLEAR) begin
            mask_nxt = '0;
        end
        if (restart) mask_nxt = '0;

        if (cur_state == ST_NEWBOARD && nxt_state == ST_GEN) begin
            lines_nxt    = '0;
            level_nxt    = '0;
            progress_nxt = '0;
        end else if (clr_evt) begin
            lines_nxt = lines_sum[SUM_W-1] ? {LINE_W{1'b1}} : lines_sum[LINE_W-1:0];
            // Only one level step per clear; leftover progress carries forward.
            if (prog_sat >= PROG_W'(LINES_PER_LEVEL)) begin
                progress_nxt = prog_sat - PROG_W'(LINES_PER_LEVEL);
                if (level != LVL_W'(MAX_LEVEL)) level_nxt = level + LVL_W'(1);
            end else begin
                progress_nxt = prog_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            cur_state   <= ST_NEWBOARD;
            tmr         <= '0;
            progress    <= '0;
            start_gen   <= 1'b0;
            start_move  <= 1'b0;
            start_land  <= 1'b0;
            start_clear <= 1'b0;
            drop_tick   <= 1'b0;
            clear_mask  <= '0;
            lines_total <= '0;
            level       <= '0;
            game_over   <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            tmr         <= tmr_nxt;
            progress    <= progress_nxt;
            start_gen   <= (nxt_state == ST_GEN)   && (cur_state != ST_GEN);
            start_move  <= (nxt_state == ST_MOVE)  && (cur_state == ST_GEN);
            start_land  <= (nxt_state == ST_LAND)  && (cur_state != ST_LAND);
            start_clear <= (nxt_state == ST_CLEAR) && (cur_state != ST_CLEAR);
            drop_tick   <= tick_nxt;
            clear_mask  <= mask_nxt;
            lines_total <= lines_nxt;
            level       <= level_nxt;
            game_over   <= (nxt_state == ST_GAMEOVER);
        end
    end

endmodule
